// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I 5-stage core.
// Holds the decoded bundle for EX and detects load-use hazards.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_I,
    input  logic            rst_n_I,
    input  logic            memStall_I,
    input  logic            flush_I,
    input  logic            idValid_I,
    input  logic [6:0]      opCode_I,
    input  logic            memReadEnable_I,
    input  logic            reg_W_EN_I,
    input  logic            aluSrcA_I,
    input  logic            aluSrcB_I,
    input  logic            aluOp_I,
    input  logic            memWriteEn_I,
    input  logic            branchInst_I,
    input  logic            ItypeInsts_I,
    input  logic            jumpTypeInst_I,
    input  logic [1:0]      destRegWriteSel_I,
    input  logic [XLEN-1:0] pc_I,
    input  logic [XLEN-1:0] rs1Data_I,
    input  logic [XLEN-1:0] rs2Data_I,
    input  logic [XLEN-1:0] imm_I,
    input  logic [4:0]      rs1Addr_I,
    input  logic [4:0]      rs2Addr_I,
    input  logic [4:0]      rdAddr_I,
    input  logic [2:0]      funct3_I,
    input  logic            funct7b5_I,
    output logic            exMemReadEnable_O,
    output logic            exReg_W_EN_O,
    output logic            exAluSrcA_O,
    output logic            exAluSrcB_O,
    output logic            exAluOp_O,
    output logic            exMemWriteEn_O,
    output logic            exBranchInst_O,
    output logic            exItypeInsts_O,
    output logic            exJumpTypeInst_O,
    output logic [1:0]      exDestRegWriteSel_O,
    output logic [XLEN-1:0] exPc_O,
    output logic [XLEN-1:0] exRs1Data_O,
    output logic [XLEN-1:0] exRs2Data_O,
    output logic [XLEN-1:0] exImm_O,
    output logic [4:0]      exRs1Addr_O,
    output logic [4:0]      exRs2Addr_O,
    output logic [4:0]      exRdAddr_O,
    output logic [2:0]      exFunct3_O,
    output logic            exFunct7b5_O,
    output logic            exValid_O,
    output logic            loadUseStall_O
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    typedef struct packed {
        logic       mem_read;
        logic       reg_we;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       alu_op;
        logic       mem_write;
        logic       branch;
        logic       itype;
        logic       jump;
        logic [1:0] wb_sel;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [2:0]      funct3;
        logic            funct7b5;
    } data_t;

    ctrl_t ctrl_in;
    data_t data_in;
    ctrl_t ctrl_d, ctrl_q;
    data_t data_d, data_q;
    logic  valid_d, valid_q;

    logic rs1_used;
    logic rs2_used;
    logic rs1_match;
    logic rs2_match;
    logic hazard;

    assign ctrl_in = '{
        mem_read:  memReadEnable_I,
        reg_we:    reg_W_EN_I,
        alu_src_a: aluSrcA_I,
        alu_src_b: aluSrcB_I,
        alu_op:    aluOp_I,
        mem_write: memWriteEn_I,
        branch:    branchInst_I,
        itype:     ItypeInsts_I,
        jump:      jumpTypeInst_I,
        wb_sel:    destRegWriteSel_I
    };

    assign data_in = '{
        pc:       pc_I,
        rs1_data: rs1Data_I,
        rs2_data: rs2Data_I,
        imm:      imm_I,
        rs1_addr: rs1Addr_I,
        rs2_addr: rs2Addr_I,
        rd_addr:  rdAddr_I,
        funct3:   funct3_I,
        funct7b5: funct7b5_I
    };

    // Which source registers the ID instruction actually reads
    always_comb begin
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        if (opCode_I == OP_LUI || opCode_I == OP_AUIPC ||
            opCode_I == OP_JAL) begin
            rs1_used = 1'b0;
        end
        if (opCode_I == OP_REG || opCode_I == OP_STORE ||
            opCode_I == OP_BR) begin
            rs2_used = 1'b1;
        end
    end

    assign rs1_match = rs1_used && (rs1Addr_I == data_q.rd_addr);
    assign rs2_match = rs2_used && (rs2Addr_I == data_q.rd_addr);

    assign hazard = valid_q && ctrl_q.mem_read &&
                    (data_q.rd_addr != 5'd0) && idValid_I &&
                    (rs1_match || rs2_match);

    assign loadUseStall_O = hazard && !flush_I;

    always_comb begin
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (memStall_I) begin
            ctrl_d  = ctrl_q;
        end else if (flush_I || hazard) begin
            ctrl_d  = '0;
            data_d  = '0;
            valid_d = 1'b0;
        end else begin
            // An invalid slot keeps its data but can never write state
            ctrl_d  = idValid_I ? ctrl_in : '0;
            data_d  = data_in;
            valid_d = idValid_I;
        end
    end

    always_ff @(posedge clk_I or negedge rst_n_I) begin
        if (!rst_n_I) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign exMemReadEnable_O   = ctrl_q.mem_read;
    assign exReg_W_EN_O        = ctrl_q.reg_we;
    assign exAluSrcA_O         = ctrl_q.alu_src_a;
    assign exAluSrcB_O         = ctrl_q.alu_src_b;
    assign exAluOp_O           = ctrl_q.alu_op;
    assign exMemWriteEn_O      = ctrl_q.mem_write;
    assign exBranchInst_O      = ctrl_q.branch;
    assign exItypeInsts_O      = ctrl_q.itype;
    assign exJumpTypeInst_O    = ctrl_q.jump;
    assign exDestRegWriteSel_O = ctrl_q.wb_sel;
    assign exPc_O              = data_q.pc;
    assign exRs1Data_O         = data_q.rs1_data;
    assign exRs2Data_O         = data_q.rs2_data;
    assign exImm_O             = data_q.imm;
    assign exRs1Addr_O         = data_q.rs1_addr;
    assign exRs2Addr_O         = data_q.rs2_addr;
    assign exRdAddr_O          = data_q.rd_addr;
    assign exFunct3_O          = data_q.funct3;
    assign exFunct7b5_O        = data_q.funct7b5;
    assign exValid_O           = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed pipeline scenarios plus random
// traffic checked against a behavioural pipeline-register model.
module tb_id_ex_stage;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_REG  = 7'b0110011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    // ctrl bit order: mr,we,a,b,op,mw,br,it,jmp,wb[1:0]
    localparam logic [10:0] C_LW  = 11'b1_1_0_1_0_0_0_1_0_01;
    localparam logic [10:0] C_ADD = 11'b0_1_0_0_0_0_0_0_0_00;
    localparam logic [10:0] C_LUI = 11'b0_1_0_1_0_0_0_0_0_11;

    logic clk = 1'b0;
    logic rst_n;
    logic i_ms, i_fl, i_valid;
    logic [6:0] i_op;
    logic [10:0] i_ctrl;
    logic [31:0] i_pc, i_d1, i_d2, i_imm;
    logic [4:0] i_rs1a, i_rs2a, i_rd;
    logic [2:0] i_f3;
    logic i_f7;

    logic [10:0] o_ctrl;
    logic [1:0] o_wb;
    logic o_mr, o_we, o_a, o_b, o_aop, o_mw, o_br, o_it, o_jmp;
    logic [31:0] o_pc, o_d1, o_d2, o_imm;
    logic [4:0] o_rs1a, o_rs2a, o_rd;
    logic [2:0] o_f3;
    logic o_f7, o_valid, o_stall;

    // model of the EX-side register contents
    logic e_valid;
    logic [10:0] e_ctrl;
    logic [31:0] e_pc, e_d1, e_d2, e_imm;
    logic [4:0] e_rs1a, e_rs2a, e_rd;
    logic [2:0] e_f3;
    logic e_f7;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32)) dut (
        .clk_I(clk), .rst_n_I(rst_n),
        .memStall_I(i_ms), .flush_I(i_fl),
        .idValid_I(i_valid), .opCode_I(i_op),
        .memReadEnable_I(i_ctrl[10]), .reg_W_EN_I(i_ctrl[9]),
        .aluSrcA_I(i_ctrl[8]), .aluSrcB_I(i_ctrl[7]),
        .aluOp_I(i_ctrl[6]), .memWriteEn_I(i_ctrl[5]),
        .branchInst_I(i_ctrl[4]), .ItypeInsts_I(i_ctrl[3]),
        .jumpTypeInst_I(i_ctrl[2]),
        .destRegWriteSel_I(i_ctrl[1:0]),
        .pc_I(i_pc), .rs1Data_I(i_d1), .rs2Data_I(i_d2),
        .imm_I(i_imm), .rs1Addr_I(i_rs1a), .rs2Addr_I(i_rs2a),
        .rdAddr_I(i_rd), .funct3_I(i_f3), .funct7b5_I(i_f7),
        .exMemReadEnable_O(o_mr), .exReg_W_EN_O(o_we),
        .exAluSrcA_O(o_a), .exAluSrcB_O(o_b), .exAluOp_O(o_aop),
        .exMemWriteEn_O(o_mw), .exBranchInst_O(o_br),
        .exItypeInsts_O(o_it), .exJumpTypeInst_O(o_jmp),
        .exDestRegWriteSel_O(o_wb),
        .exPc_O(o_pc), .exRs1Data_O(o_d1), .exRs2Data_O(o_d2),
        .exImm_O(o_imm), .exRs1Addr_O(o_rs1a),
        .exRs2Addr_O(o_rs2a), .exRdAddr_O(o_rd),
        .exFunct3_O(o_f3), .exFunct7b5_O(o_f7),
        .exValid_O(o_valid), .loadUseStall_O(o_stall)
    );

    assign o_ctrl = {o_mr, o_we, o_a, o_b, o_aop, o_mw,
                     o_br, o_it, o_jmp, o_wb};

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic ref_hazard();
        logic u1, u2;
        u1 = !(i_op inside {7'b0110111, 7'b0010111, 7'b1101111});
        u2 = i_op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return e_valid && e_ctrl[10] && (e_rd != 5'd0) && i_valid &&
               ((u1 && i_rs1a == e_rd) || (u2 && i_rs2a == e_rd));
    endfunction

    task automatic model_clear();
        e_valid = 1'b0; e_ctrl = '0;
        e_pc = '0; e_d1 = '0; e_d2 = '0; e_imm = '0;
        e_rs1a = '0; e_rs2a = '0; e_rd = '0;
        e_f3 = '0; e_f7 = 1'b0;
    endtask

    task automatic model_edge();
        logic hz;
        hz = ref_hazard();
        if (i_ms) begin
        end else if (i_fl || hz) begin
            model_clear();
        end else begin
            e_valid = i_valid;
            e_ctrl = i_valid ? i_ctrl : 11'd0;
            e_pc = i_pc; e_d1 = i_d1; e_d2 = i_d2; e_imm = i_imm;
            e_rs1a = i_rs1a; e_rs2a = i_rs2a; e_rd = i_rd;
            e_f3 = i_f3; e_f7 = i_f7;
        end
    endtask

    task automatic compare_regs();
        chk("valid", 64'(o_valid), 64'(e_valid));
        chk("ctrl", 64'(o_ctrl), 64'(e_ctrl));
        chk("pc", 64'(o_pc), 64'(e_pc));
        chk("rs1data", 64'(o_d1), 64'(e_d1));
        chk("rs2data", 64'(o_d2), 64'(e_d2));
        chk("imm", 64'(o_imm), 64'(e_imm));
        chk("addrs", 64'({o_rs1a, o_rs2a, o_rd}),
            64'({e_rs1a, e_rs2a, e_rd}));
        chk("funct", 64'({o_f3, o_f7}), 64'({e_f3, e_f7}));
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge
    task automatic step();
        #1;
        chk("stall", 64'(o_stall), 64'(ref_hazard() && !i_fl));
        @(posedge clk);
        model_edge();
        #1;
        compare_regs();
        @(negedge clk);
    endtask

    task automatic instr(input logic [6:0] op, input logic [10:0] c,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] rd);
        i_valid = 1'b1; i_fl = 1'b0; i_ms = 1'b0;
        i_op = op; i_ctrl = c;
        i_rs1a = a1; i_rs2a = a2; i_rd = rd;
        i_pc = $urandom; i_d1 = $urandom; i_d2 = $urandom;
        i_imm = $urandom; i_f3 = 3'($urandom); i_f7 = 1'($urandom);
    endtask

    task automatic rand_inputs();
        logic [6:0] ops [9];
        ops = '{OP_LOAD, OP_REG, 7'b0100011, 7'b1100011, OP_LUI,
                7'b0010111, 7'b1101111, 7'b0010011, 7'b1100111};
        i_op = ops[$urandom_range(0, 8)];
        i_ctrl = 11'($urandom);
        i_ctrl[10] = (i_op == OP_LOAD) ? ($urandom_range(0, 9) != 0)
                                       : ($urandom_range(0, 9) == 0);
        i_valid = $urandom_range(0, 99) < 85;
        i_ms = $urandom_range(0, 99) < 10;
        i_fl = $urandom_range(0, 99) < 10;
        i_rs1a = 5'($urandom_range(0, 3));
        i_rs2a = 5'($urandom_range(0, 3));
        i_rd = 5'($urandom_range(0, 3));
        i_pc = $urandom; i_d1 = $urandom; i_d2 = $urandom;
        i_imm = $urandom; i_f3 = 3'($urandom); i_f7 = 1'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        model_clear();
        rand_inputs();
        i_ms = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        compare_regs();
        chk("rst_stall", 64'(o_stall), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // passthrough
        instr(OP_REG, C_ADD, 5'd1, 5'd2, 5'd5);
        i_d1 = 32'h11; i_d2 = 32'h22;
        step();
        chk("pt_rs1", 64'(o_d1), 64'h11);
        chk("pt_rs2", 64'(o_d2), 64'h22);
        chk("pt_rd", 64'(o_rd), 64'd5);
        chk("pt_we", 64'(o_we), 64'd1);
        chk("pt_valid", 64'(o_valid), 64'd1);

        // load-use on rs2
        instr(OP_LOAD, C_LW, 5'd1, 5'd0, 5'd7);
        step();
        instr(OP_REG, C_ADD, 5'd1, 5'd7, 5'd8);
        #1;
        chk("lu_stall", 64'(o_stall), 64'd1);
        step();
        chk("lu_bub_valid", 64'(o_valid), 64'd0);
        chk("lu_bub_we", 64'(o_we), 64'd0);
        #1;
        chk("lu_stall_after", 64'(o_stall), 64'd0);
        step();
        chk("lu_add_valid", 64'(o_valid), 64'd1);
        chk("lu_add_rd", 64'(o_rd), 64'd8);

        // x0 destination
        instr(OP_LOAD, C_LW, 5'd2, 5'd0, 5'd0);
        step();
        instr(OP_REG, C_ADD, 5'd0, 5'd0, 5'd9);
        #1;
        chk("x0_stall", 64'(o_stall), 64'd0);
        step();

        // dependent LUI
        instr(OP_LOAD, C_LW, 5'd2, 5'd0, 5'd3);
        step();
        instr(OP_LUI, C_LUI, 5'd3, 5'd3, 5'd10);
        #1;
        chk("lui_stall", 64'(o_stall), 64'd0);
        step();

        // flush beats hazard
        instr(OP_LOAD, C_LW, 5'd2, 5'd0, 5'd4);
        step();
        instr(OP_REG, C_ADD, 5'd4, 5'd1, 5'd11);
        i_fl = 1'b1;
        #1;
        chk("fl_stall", 64'(o_stall), 64'd0);
        step();
        chk("fl_bub_valid", 64'(o_valid), 64'd0);
        chk("fl_bub_pc", 64'(o_pc), 64'd0);

        // memory-stall hold
        instr(OP_REG, C_ADD, 5'd1, 5'd2, 5'd12);
        i_d1 = 32'hAAAA;
        step();
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            i_ms = 1'b1;
            step();
            chk("hold_rs1", 64'(o_d1), 64'hAAAA);
            chk("hold_rd", 64'(o_rd), 64'd12);
        end
        instr(OP_REG, C_ADD, 5'd1, 5'd2, 5'd13);
        i_d1 = 32'h1234;
        step();
        chk("rel_rs1", 64'(o_d1), 64'h1234);

        // async reset during a stall
        rand_inputs();
        i_ms = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        compare_regs();
        chk("ar_valid", 64'(o_valid), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        instr(OP_REG, C_ADD, 5'd1, 5'd2, 5'd14);
        i_pc = 32'h40;
        step();
        chk("post_rst_pc", 64'(o_pc), 64'h40);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rand_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the RV32I 5-stage core. Sits directly downstream of the opcode control decoder and register file read.
- Captures the decoded control bundle, operands, immediate and register addresses each cycle, and presents them to the EX stage.
- Contains load-use hazard detection: asserts a stall request to PC/IF-ID and inserts a bubble.
- Supports a branch/jump flush from EX and a global memory-stall hold.

Parameters:
XLEN, 32, datapath width (PC, operands, immediate)

Ports:
clk_I  input  1  core clock, all state on rising edge
rst_n_I  input  1  asynchronous active-low reset
memStall_I  input  1  global hold; freeze all ID/EX state
flush_I  input  1  EX redirect (taken branch/jump); kill the instruction entering ID/EX
idValid_I  input  1  ID holds a real instruction
opCode_I  input  7  ID instruction opcode, for operand-use decode
memReadEnable_I, reg_W_EN_I, aluSrcA_I, aluSrcB_I, aluOp_I, memWriteEn_I, branchInst_I, ItypeInsts_I, jumpTypeInst_I  input  1 each  decoder control bits
destRegWriteSel_I  input  2  writeback mux select
pc_I  input  XLEN  ID PC
rs1Data_I, rs2Data_I  input  XLEN  register file read data
imm_I  input  XLEN  sign-extended immediate
rs1Addr_I, rs2Addr_I, rdAddr_I  input  5  register indices
funct3_I  input  3  instruction funct3
funct7b5_I  input  1  instruction bit 30
ex*_O  output  same widths  registered copies of every *_I above except opCode_I, idValid_I, memStall_I and flush_I (exMemReadEnable_O ... exFunct7b5_O)
exValid_O  output  1  EX holds a real instruction
loadUseStall_O  output  1  combinational; freeze PC and IF/ID, this cycle

Behaviour:
- Reset (rst_n_I=0, asynchronous): every ex*_O and exValid_O is 0. loadUseStall_O is 0 because it depends on exValid_O.
- Operand use from opCode_I:
  - rs1Used = 0 for 0110111 (LUI), 0010111 (AUIPC) and 1101111 (JAL); 1 otherwise.
  - rs2Used = 1 only for 0110011, 0100011 and 1100011.
- hazard = exValid_O & exMemReadEnable_O & (exRdAddr_O != 0) & idValid_I & ((rs1Used & rs1Addr_I == exRdAddr_O) | (rs2Used & rs2Addr_I == exRdAddr_O)).
- loadUseStall_O = hazard & ~flush_I. It has zero latency and is a pure function of current inputs and registered state.
- Per-edge update, in priority order:
  1. memStall_I=1: hold all registers.
  2. flush_I=1: bubble.
  3. hazard=1: bubble. ID content is held upstream and re-presented next cycle.
  4. Otherwise: load all *_I. exValid_O <= idValid_I.
- Bubble: exValid_O and every control output is 0 (including destRegWriteSel=00), and every datapath/address output is 0.
- Load with idValid_I=0: all control outputs are forced to 0. Datapath fields load normally. This way an invalid slot can never write the register file or memory.
- Latency: 1 cycle from ID inputs to ex*_O.
- A load-use sequence costs exactly one bubble. The cycle after the bubble, EX holds the non-load, so hazard=0.
- A load followed by a second dependent load still gives one bubble per dependence.
- x0 destination never triggers a hazard.
- A store whose rs2 depends on a preceding load stalls (rs2Used=1). A dependent LUI never stalls.
- flush_I and hazard in the same cycle: bubble, and loadUseStall_O=0. IF/ID is flushed upstream.
- memStall_I with flush_I: hold. EX is also held, so the flush reasserts after the stall.
- Reset mid-stall clears immediately; the first post-reset edge loads normally.

Test Plan:
- Reset: drive nonzero inputs, pulse rst_n_I low asynchronously between edges -> all ex*_O = 0 and exValid_O = 0 immediately, before the next edge.
- Passthrough: idValid_I=1, ADD (0110011) with rs1Data_I=0x11, rs2Data_I=0x22, rd=5, reg_W_EN_I=1 -> one edge later exRs1Data_O=0x11, exRs2Data_O=0x22, exRdAddr_O=5, exReg_W_EN_O=1, exValid_O=1.
- Load-use: EX holds LW with rd=7; ID presents ADD with rs2=7 -> loadUseStall_O=1 in that cycle; next edge gives a bubble (exValid_O=0, exReg_W_EN_O=0); following cycle loadUseStall_O=0 and the ADD loads.
- No false hazard:
  - EX holds LW with rd=0 and ID uses rs1=0 -> loadUseStall_O=0.
  - EX holds LW with rd=3 and ID is LUI with rs1 field=3 -> loadUseStall_O=0.
- Flush priority: EX holds LW with rd=4, ID uses rs1=4, flush_I=1 -> loadUseStall_O=0; next edge gives a bubble.
- Hold: memStall_I=1 for 3 cycles with changing inputs -> ex*_O unchanged for those cycles; on release the current inputs load on the next edge.
